ras_ckpt: RTL

- Circular return-address stack with speculative checkpoint/repair; next generation of the frontend RAS.
- Supports parametrised depth with wrap-on-overflow and an occupancy count.
- Up to NUM_CKPT in-flight branch checkpoints (top pointer, count and top entry) allow the stack to be repaired on mispredict instead of only flushed.
- Sits in the frontend next to the BTB/BHT. Push/pop come from predecode; checkpoint/restore/release come from branch resolution.

---
 rtl/ras_ckpt_pkg.sv | 25 ++
 rtl/ras_ckpt_fifo.sv | 117 +++++++++++
 rtl/ras_ckpt.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ras_ckpt_pkg.sv
// Frontend return-address-stack package.
// Holds the stack entry type, the checkpoint record for the default
// geometry, and the default depth / checkpoint-slot counts.
package ras_ckpt_pkg;

   localparam int unsigned VLEN         = 32;
   localparam int unsigned RAS_DEPTH    = 16;
   localparam int unsigned RAS_NUM_CKPT = 4;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] ra;
   } ras_t;

   localparam ras_t RAS_NULL = '{valid: 1'b0, ra: {VLEN{1'b0}}};

   // Checkpoint record for the default geometry; ras_ckpt rebuilds the same
   // layout locally when DEPTH is overridden.
   typedef struct packed {
      logic [$clog2(RAS_DEPTH)-1:0]   tos;
      logic [$clog2(RAS_DEPTH+1)-1:0] count;
      ras_t                           entry;
   } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_fifo.sv
// Checkpoint FIFO for the return-address stack.
// NUM_CKPT slots of W bits each, allocated at tail and released at head.
// A truncate to a live id moves tail back to that id, freeing it and every
// younger slot in one cycle.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             drop all checkpoints
//   alloc_i/alloc_data_i  write a new slot at tail (ignored when full)
//   release_i         free the oldest slot (ignored when empty)
//   trunc_i/trunc_id_i    truncate to trunc_id_i if that id is live
//   ready_o           a free slot exists
//   tail_o            id the next allocation receives
//   trunc_hit_o       trunc_i targets a live id this cycle
//   trunc_data_o      contents of slot trunc_id_i
module ras_ckpt_fifo #(
   parameter int unsigned NUM_CKPT = 4,
   parameter int unsigned W        = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clr_i,
   input  logic                        alloc_i,
   input  logic [W-1:0]                alloc_data_i,
   input  logic                        release_i,
   input  logic                        trunc_i,
   input  logic [$clog2(NUM_CKPT)-1:0] trunc_id_i,
   output logic                        ready_o,
   output logic [$clog2(NUM_CKPT)-1:0] tail_o,
   output logic                        trunc_hit_o,
   output logic [W-1:0]                trunc_data_o
);

   localparam int unsigned ID_W   = $clog2(NUM_CKPT);
   localparam int unsigned LIVE_W = $clog2(NUM_CKPT+1);
   localparam logic [ID_W-1:0]   ID_ZERO   = {ID_W{1'b0}};
   localparam logic [ID_W-1:0]   ID_ONE    = ID_W'(1);
   localparam logic [LIVE_W-1:0] LIVE_ZERO = {LIVE_W{1'b0}};
   localparam logic [LIVE_W-1:0] LIVE_ONE  = LIVE_W'(1);
   localparam logic [LIVE_W-1:0] LIVE_FULL = LIVE_W'(NUM_CKPT);

   logic [W-1:0]      slot_q [NUM_CKPT];
   logic [W-1:0]      slot_d [NUM_CKPT];
   logic [ID_W-1:0]   head_q, head_d;
   logic [ID_W-1:0]   tail_q, tail_d;
   logic [LIVE_W-1:0] live_q, live_d;

   logic [ID_W-1:0] offset_s;
   logic            ready_s;
   logic            trunc_hit_s;
   logic            alloc_ok_s;
   logic            rel_ok_s;

   // Liveness of the truncate target: its distance from head must be below live.
   always_comb begin
      offset_s    = trunc_id_i - head_q;
      ready_s     = (live_q < LIVE_FULL);
      trunc_hit_s = trunc_i && (LIVE_W'(offset_s) < live_q);
      alloc_ok_s  = alloc_i && ready_s;
      rel_ok_s    = release_i && (live_q != LIVE_ZERO);
   end

   // Next-state: clear beats truncate, truncate drops same-cycle alloc/release.
   always_comb begin
      slot_d = slot_q;
      head_d = head_q;
      tail_d = tail_q;
      live_d = live_q;
      if (clr_i) begin
         slot_d = '{default: {W{1'b0}}};
         head_d = ID_ZERO;
         tail_d = ID_ZERO;
         live_d = LIVE_ZERO;
      end else if (trunc_hit_s) begin
         // Everything from head up to (not including) the target stays live.
         tail_d = trunc_id_i;
         live_d = LIVE_W'(offset_s);
      end else begin
         if (alloc_ok_s) begin
            slot_d[tail_q] = alloc_data_i;
            tail_d         = tail_q + ID_ONE;
         end else begin
            tail_d = tail_q;
         end
         if (rel_ok_s) begin
            head_d = head_q + ID_ONE;
         end else begin
            head_d = head_q;
         end
         case ({alloc_ok_s, rel_ok_s})
            2'b10:   live_d = live_q + LIVE_ONE;
            2'b01:   live_d = live_q - LIVE_ONE;
            default: live_d = live_q;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q <= '{default: {W{1'b0}}};
         head_q <= ID_ZERO;
         tail_q <= ID_ZERO;
         live_q <= LIVE_ZERO;
      end else begin
         slot_q <= slot_d;
         head_q <= head_d;
         tail_q <= tail_d;
         live_q <= live_d;
      end
   end

   assign ready_o      = ready_s;
   assign tail_o       = tail_q;
   assign trunc_hit_o  = trunc_hit_s;
   assign trunc_data_o = slot_q[trunc_id_i];

endmodule

// File: rtl/ras_ckpt.sv
// Circular return-address stack with speculative checkpoint/repair.
// Push/pop come from predecode; ckpt/restore/release from branch resolution.
// A push on a full stack wraps and overwrites the oldest entry. Restore
// rebuilds tos, count and the top entry from a live checkpoint.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_bp_i           clear stack and all checkpoints
//   push_i, pop_i, data_i  stack operations (push+pop replaces the top)
//   data_o, count_o      current top entry (valid iff non-empty), occupancy
//   ckpt_i, ckpt_ready_o, ckpt_id_o   checkpoint allocation
//   restore_i, restore_id_i           repair from a live checkpoint
//   release_i            free the oldest checkpoint
module ras_ckpt
   import ras_ckpt_pkg::*;
#(
   parameter int unsigned DEPTH    = RAS_DEPTH,
   parameter int unsigned NUM_CKPT = RAS_NUM_CKPT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_bp_i,
   input  logic                        push_i,
   input  logic                        pop_i,
   input  logic [VLEN-1:0]             data_i,
   output ras_t                        data_o,
   output logic [$clog2(DEPTH+1)-1:0]  count_o,
   input  logic                        ckpt_i,
   output logic                        ckpt_ready_o,
   output logic [$clog2(NUM_CKPT)-1:0] ckpt_id_o,
   input  logic                        restore_i,
   input  logic [$clog2(NUM_CKPT)-1:0] restore_id_i,
   input  logic                        release_i
);

   localparam int unsigned TOS_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [TOS_W-1:0] TOS_ZERO = {TOS_W{1'b0}};
   localparam logic [TOS_W-1:0] TOS_ONE  = TOS_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   typedef struct packed {
      logic [TOS_W-1:0] tos;
      logic [CNT_W-1:0] count;
      ras_t             entry;
   } ckpt_t;

   localparam int unsigned CKPT_W = $bits(ckpt_t);

   ras_t             stack_q [DEPTH];
   ras_t             stack_d [DEPTH];
   logic [TOS_W-1:0] tos_q, tos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   ckpt_t ckpt_wr_s;
   ckpt_t ckpt_rd_s;
   logic  restore_hit_s;

   // Stack next-state; restore suppresses this cycle's push/pop.
   always_comb begin
      stack_d = stack_q;
      tos_d   = tos_q;
      cnt_d   = cnt_q;
      if (flush_bp_i) begin
         stack_d = '{default: RAS_NULL};
         tos_d   = TOS_ZERO;
         cnt_d   = CNT_ZERO;
      end else if (restore_hit_s) begin
         tos_d          = ckpt_rd_s.tos;
         cnt_d          = ckpt_rd_s.count;
         stack_d[tos_d] = ckpt_rd_s.entry;
      end else begin
         case ({push_i, pop_i})
            2'b11: begin
               // Replace the top in place; an empty stack gains one entry.
               stack_d[tos_q] = '{valid: 1'b1, ra: data_i};
               if (cnt_q == CNT_ZERO) begin
                  cnt_d = CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
            end
            2'b10: begin
               tos_d          = tos_q + TOS_ONE;
               stack_d[tos_d] = '{valid: 1'b1, ra: data_i};
               // Saturate: when full the push overwrites the oldest slot.
               if (cnt_q == CNT_FULL) begin
                  cnt_d = cnt_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            2'b01: begin
               if (cnt_q != CNT_ZERO) begin
                  stack_d[tos_q] = RAS_NULL;
                  tos_d          = tos_q - TOS_ONE;
                  cnt_d          = cnt_q - CNT_ONE;
               end else begin
                  tos_d = tos_q;
               end
            end
            default: begin
               tos_d = tos_q;
            end
         endcase
      end
      // Checkpoints capture the post-update state, including this cycle's op.
      ckpt_wr_s = '{tos: tos_d, count: cnt_d, entry: stack_d[tos_d]};
   end

   // Stack registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stack_q <= '{default: RAS_NULL};
         tos_q   <= TOS_ZERO;
         cnt_q   <= CNT_ZERO;
      end else begin
         stack_q <= stack_d;
         tos_q   <= tos_d;
         cnt_q   <= cnt_d;
      end
   end

   // Top-of-stack view: all zero while empty.
   always_comb begin
      if (cnt_q != CNT_ZERO) begin
         data_o = stack_q[tos_q];
      end else begin
         data_o = RAS_NULL;
      end
   end

   assign count_o = cnt_q;

   ras_ckpt_fifo #(
      .NUM_CKPT (NUM_CKPT),
      .W        (CKPT_W)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (flush_bp_i),
      .alloc_i      (ckpt_i),
      .alloc_data_i (ckpt_wr_s),
      .release_i    (release_i),
      .trunc_i      (restore_i),
      .trunc_id_i   (restore_id_i),
      .ready_o      (ckpt_ready_o),
      .tail_o       (ckpt_id_o),
      .trunc_hit_o  (restore_hit_s),
      .trunc_data_o (ckpt_rd_s)
   );

endmodule
